// File: rtl/pe_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_array
// Description : Pipelined LANES-wide signed Q-format MAC with a saturating adder
//               tree and packet accumulator. Runtime FUSED / SPLIT reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_array #(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int LANES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [LANES*N-1:0]     in_data,
    input  logic [LANES*N-1:0]     w_data,
    output logic                   out_valid,
    output logic [(LANES/2)*N-1:0] out_data,
    output logic                   out_sat,
    output logic                   out_mode
);
    localparam int c_TREE  = $clog2(LANES);
    localparam int c_SLOTS = LANES / 2;
    localparam int c_NODES = 2 * LANES - 1;
    localparam int c_ROOT  = c_NODES - 1;
    localparam logic signed [N-1:0] c_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] c_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    // Result is {saturated, value}.
    function automatic logic [N:0] f_sat_add(input logic signed [N-1:0] a,
                                             input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1]) return {1'b1, (s[N] ? c_MIN : c_MAX)};
        return {1'b0, s[N-1:0]};
    endfunction

    function automatic logic [N:0] f_qmul(input logic signed [N-1:0] a,
                                          input logic signed [N-1:0] b);
        logic signed [2*N-1:0] ae;
        logic signed [2*N-1:0] be;
        logic signed [2*N-1:0] p;
        logic signed [2*N-1:0] sh;
        ae = {{N{a[N-1]}}, a};
        be = {{N{b[N-1]}}, b};
        p  = ae * be;
        sh = p >>> Q;
        if (sh[2*N-1:N-1] != {(N+1){sh[2*N-1]}}) return {1'b1, (sh[2*N-1] ? c_MIN : c_MAX)};
        return {1'b0, sh[N-1:0]};
    endfunction

    // Heap layout: leaves (products) at 0..LANES-1, level l starts at f_base(l).
    function automatic int f_base(input int l);
        return 2 * LANES - 2 * (LANES >> l);
    endfunction

    logic signed [N-1:0] r_node [c_NODES];
    logic signed [N-1:0] w_node [c_NODES];
    logic [c_TREE:0]     w_lvl_sat;
    logic [N:0]          w_tree_tmp;
    logic signed [N-1:0] r_pair [c_TREE][c_SLOTS];
    logic [c_TREE:0]     r_vld;
    logic [c_TREE:0]     r_last;
    logic [c_TREE:0]     r_mode;
    logic [c_TREE:0]     r_sat_s;
    logic [c_TREE:0]     r_sat_f;

    always_comb begin
        w_lvl_sat  = '0;
        w_tree_tmp = '0;
        for (int i = 0; i < c_NODES; i++) w_node[i] = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree_tmp   = f_qmul(in_data[i*N +: N], w_data[i*N +: N]);
            w_node[i]    = w_tree_tmp[N-1:0];
            w_lvl_sat[0] = w_lvl_sat[0] | w_tree_tmp[N];
        end
        for (int l = 1; l <= c_TREE; l++) begin
            for (int i = 0; i < (LANES >> l); i++) begin
                w_tree_tmp = f_sat_add(r_node[f_base(l-1) + 2*i], r_node[f_base(l-1) + 2*i + 1]);
                w_node[f_base(l) + i] = w_tree_tmp[N-1:0];
                w_lvl_sat[l] = w_lvl_sat[l] | w_tree_tmp[N];
            end
        end
    end

    // SPLIT only cares about product and level-1 saturation; FUSED about every level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NODES; i++) r_node[i] <= '0;
            for (int k = 0; k < c_TREE; k++)
                for (int j = 0; j < c_SLOTS; j++) r_pair[k][j] <= '0;
            r_vld   <= '0;
            r_last  <= '0;
            r_mode  <= '0;
            r_sat_s <= '0;
            r_sat_f <= '0;
        end else begin
            for (int i = 0; i < c_NODES; i++) r_node[i] <= w_node[i];
            for (int j = 0; j < c_SLOTS; j++) r_pair[0][j] <= w_node[LANES + j];
            for (int k = 1; k < c_TREE; k++)
                for (int j = 0; j < c_SLOTS; j++) r_pair[k][j] <= r_pair[k-1][j];
            r_vld      <= {r_vld[c_TREE-1:0], in_valid};
            r_last     <= {r_last[c_TREE-1:0], in_valid & in_last};
            r_mode     <= {r_mode[c_TREE-1:0], mode};
            r_sat_s[0] <= w_lvl_sat[0];
            r_sat_f[0] <= w_lvl_sat[0];
            for (int l = 1; l <= c_TREE; l++) begin
                r_sat_s[l] <= r_sat_s[l-1] | ((l == 1) && w_lvl_sat[l]);
                r_sat_f[l] <= r_sat_f[l-1] | w_lvl_sat[l];
            end
        end
    end

    state_t              r_state;
    logic                r_pkt_mode;
    logic                r_acc_sat;
    logic signed [N-1:0] r_acc [c_SLOTS];
    logic                w_pkt_mode;
    logic                w_beat_sat;
    logic                w_nxt_sat;
    logic [N:0]          w_acc_tmp;
    logic signed [N-1:0] w_sum [c_SLOTS];
    logic signed [N-1:0] w_nxt [c_SLOTS];

    always_comb begin
        w_pkt_mode = (r_state == IDLE) ? r_mode[c_TREE] : r_pkt_mode;
        w_beat_sat = w_pkt_mode ? r_sat_s[c_TREE] : r_sat_f[c_TREE];
        w_nxt_sat  = w_beat_sat | ((r_state == ACCUM) && r_acc_sat);
        w_acc_tmp  = '0;
        for (int j = 0; j < c_SLOTS; j++) begin
            if (w_pkt_mode)  w_sum[j] = r_pair[c_TREE-1][j];
            else if (j == 0) w_sum[j] = r_node[c_ROOT];
            else             w_sum[j] = '0;
            if (r_state == ACCUM) begin
                w_acc_tmp = f_sat_add(r_acc[j], w_sum[j]);
                w_nxt[j]  = w_acc_tmp[N-1:0];
                w_nxt_sat = w_nxt_sat | w_acc_tmp[N];
            end else begin
                w_nxt[j] = w_sum[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pkt_mode <= 1'b0;
            r_acc_sat  <= 1'b0;
            for (int j = 0; j < c_SLOTS; j++) r_acc[j] <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            out_mode   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (r_vld[c_TREE]) begin
                if (r_last[c_TREE]) begin
                    out_valid <= 1'b1;
                    out_sat   <= w_nxt_sat;
                    out_mode  <= w_pkt_mode;
                    for (int j = 0; j < c_SLOTS; j++) out_data[j*N +: N] <= w_nxt[j];
                    r_state   <= IDLE;
                end else begin
                    for (int j = 0; j < c_SLOTS; j++) r_acc[j] <= w_nxt[j];
                    r_acc_sat  <= w_nxt_sat;
                    r_pkt_mode <= w_pkt_mode;
                    r_state    <= ACCUM;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pe_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mac_array
// Description : Directed scoreboard bench for pe_mac_array (LANES=8, N=32, Q=15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_array;
    logic         clk;
    logic         rst;
    logic         mode;
    logic         in_valid;
    logic         in_last;
    logic [255:0] in_data;
    logic [255:0] w_data;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_sat;
    logic         out_mode;

    typedef struct packed {
        logic [127:0] data;
        logic         sat;
        logic         mode;
        logic [31:0]  cyc;
        logic [15:0]  id;
    } exp_t;

    exp_t         sb [$];
    exp_t         r_e;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    int           n_pkt    = 0;
    logic [255:0] w_ramp;

    pe_mac_array #(.N(32), .Q(15), .LANES(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_mode  (out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] f_fill(input logic [31:0] v);
        return {8{v}};
    endfunction

    function automatic logic [127:0] f_slots(input logic [31:0] s0, input logic [31:0] s1,
                                             input logic [31:0] s2, input logic [31:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic beat(input logic [255:0] d, input logic [255:0] w, input logic m, input logic last);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_last  = last;
        mode     = m;
        in_data  = d;
        w_data   = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Called right after the last beat is driven; result is due 5 cycles later.
    task automatic expect_pkt(input logic [127:0] d, input logic sat, input logic m);
        exp_t e;
        e.data = d;
        e.sat  = sat;
        e.mode = m;
        e.cyc  = 32'(cyc + 5);
        e.id   = 16'(n_pkt);
        n_pkt++;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
                r_e = sb.pop_front();
                chk($sformatf("pkt%0d_data", r_e.id), out_data, r_e.data);
                chk($sformatf("pkt%0d_sat", r_e.id), out_sat, r_e.sat);
                chk($sformatf("pkt%0d_mode", r_e.id), out_mode, r_e.mode);
                chk($sformatf("pkt%0d_latency", r_e.id), 32'(cyc), r_e.cyc);
            end
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) w_ramp[k*32 +: 32] = 32'(4096 * (k + 1));
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; w_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_sat", out_sat, 1'b0);
        chk("rst_out_mode", out_mode, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // FUSED single beat: 8 x (1.0 * 0.5)
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b1);
        expect_pkt(f_slots(131072, 0, 0, 0), 1'b0, 1'b0);
        idle(1);
        // SPLIT single beat with ramp weights
        beat(f_fill(32768), w_ramp, 1'b1, 1'b1);
        expect_pkt(f_slots(12288, 28672, 45056, 61440), 1'b0, 1'b1);
        idle(1);
        // FUSED 3-beat packet with a 2-cycle gap before the last beat
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b0);
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b0);
        idle(2);
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b1);
        expect_pkt(f_slots(393216, 0, 0, 0), 1'b0, 1'b0);
        idle(1);
        // Positive saturation, then a clean packet must clear out_sat
        beat(f_fill(32'h7FFF_FFFF), f_fill(32'h7FFF_FFFF), 1'b0, 1'b1);
        expect_pkt(f_slots(32'h7FFF_FFFF, 0, 0, 0), 1'b1, 1'b0);
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b1);
        expect_pkt(f_slots(131072, 0, 0, 0), 1'b0, 1'b0);
        // Negative product floors: (-1 * 1) >>> 15 = -1 per lane
        beat(f_fill(32'hFFFF_FFFF), f_fill(32'd1), 1'b0, 1'b1);
        expect_pkt(f_slots(32'hFFFF_FFF8, 0, 0, 0), 1'b0, 1'b0);
        // Negative saturation to the minimum
        beat(f_fill(32'h8000_0000), f_fill(32'h7FFF_FFFF), 1'b0, 1'b1);
        expect_pkt(f_slots(32'h8000_0000, 0, 0, 0), 1'b1, 1'b0);
        // Mode change on the second beat is ignored: packet stays SPLIT
        beat(f_fill(32768), w_ramp, 1'b1, 1'b0);
        beat(f_fill(32768), w_ramp, 1'b0, 1'b1);
        expect_pkt(f_slots(24576, 57344, 90112, 122880), 1'b0, 1'b1);
        idle(8);

        // Reset mid-packet discards the partial packet and in-flight beats
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b0);
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b1);
        expect_pkt(f_slots(131072, 0, 0, 0), 1'b0, 1'b0);
        idle(1);

        // Alternating mode, back-to-back single-beat packets
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b1);
        expect_pkt(f_slots(131072, 0, 0, 0), 1'b0, 1'b0);
        beat(f_fill(32768), w_ramp, 1'b1, 1'b1);
        expect_pkt(f_slots(12288, 28672, 45056, 61440), 1'b0, 1'b1);
        beat(f_fill(32768), f_fill(16384), 1'b0, 1'b1);
        expect_pkt(f_slots(131072, 0, 0, 0), 1'b0, 1'b0);
        beat(f_fill(32768), w_ramp, 1'b1, 1'b1);
        expect_pkt(f_slots(12288, 28672, 45056, 61440), 1'b0, 1'b1);
        idle(1);

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
